// File: rtl/mux_display_mensagens.sv
// mux_display_mensagens: scanned N-digit 7-segment message driver with frame-synchronous message switching.
// Define PISCAR_EN to blink the sensor-error message ("ErSn") every PERIODO_PISCA frames.
module mux_display_mensagens #(
  parameter int NUM_DIGITOS   = 4,
  parameter int DIV_VARREDURA = 50000,
  parameter int BLANK_CICLOS  = 2,
  parameter int PERIODO_PISCA = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilitar,
  input  logic [1:0]             sel_mensagem,
  input  logic                   carregar,
  output logic [6:0]             segmentos,
  output logic [NUM_DIGITOS-1:0] anodos,
  output logic                   quadro_fim
);
  localparam int MX = DIV_VARREDURA > BLANK_CICLOS ? DIV_VARREDURA : (BLANK_CICLOS > 1 ? BLANK_CICLOS : 1);
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam int IW = NUM_DIGITOS > 1 ? $clog2(NUM_DIGITOS) : 1;
  localparam logic [CW-1:0] D_LAST = CW'(DIV_VARREDURA - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CICLOS > 0 ? BLANK_CICLOS - 1 : 0);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITOS - 1);
  localparam logic [1:0] OFF = 2'd0, BLANK = 2'd1, LIT = 2'd2;
  localparam logic [1:0] FIRST = BLANK_CICLOS == 0 ? LIT : BLANK;
  localparam logic [6:0] C_E = 7'b1001111, C_R = 7'b0000101, C_S = 7'b1011011, C_N = 7'b0010101;
  localparam logic [6:0] C_C = 7'b1001110, C_A = 7'b1110111, C_F = 7'b1000111, C_D = 7'b0000001;
  logic [1:0]    st, es, st_n, act, act_n, pend;
  logic [CW-1:0] cnt, ec, cnt_n;
  logic [IW-1:0] idx, ei, idx_n;
  logic          slot_end, frame_end, vis, show;
  logic [27:0]   msg, sh;
`ifdef PISCAR_EN
  localparam int FW = 2 * PERIODO_PISCA > 1 ? $clog2(2 * PERIODO_PISCA) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(2 * PERIODO_PISCA - 1);
  logic [FW-1:0] fc;
  always_ff @(posedge clock or posedge reset)
    if (reset) fc <= '0;
    else if (frame_end) fc <= (act != 2'd1 || act_n != 2'd1 || fc == F_LAST) ? '0 : fc + 1'b1;
`endif
  // OFF behaves exactly like the first cycle of a fresh frame, so re-enable timing matches reset release
  always_comb begin
    es = st == OFF ? FIRST : st;
    ec = st == OFF ? '0 : cnt;
    ei = st == OFF ? '0 : idx;
    slot_end = es == LIT && ec == D_LAST;
    frame_end = habilitar && slot_end && ei == I_LAST;
    st_n = !habilitar ? OFF : es == BLANK ? (ec == B_LAST ? LIT : BLANK) : (slot_end ? FIRST : LIT);
    cnt_n = (!habilitar || (es == BLANK && ec == B_LAST) || slot_end) ? '0 : ec + 1'b1;
    idx_n = !habilitar ? '0 : slot_end ? (ei == I_LAST ? '0 : ei + 1'b1) : ei;
    act_n = frame_end ? (carregar ? sel_mensagem : pend) : act;
    msg = act == 2'd1 ? {C_E, C_R, C_S, C_N} : act == 2'd2 ? {C_C, C_A, C_F, C_E} :
          act == 2'd3 ? {4{C_D}} : 28'd0;
    sh = msg << (7 * ei);
`ifdef PISCAR_EN
    vis = act != 2'd1 || fc < FW'(PERIODO_PISCA);
`else
    vis = 1'b1;
`endif
    show = habilitar && es == LIT && vis;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= FIRST;
      cnt <= '0;
      idx <= '0;
      act <= '0;
      pend <= '0;
      segmentos <= '0;
      anodos <= '0;
      quadro_fim <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
      act <= act_n;
      pend <= carregar ? sel_mensagem : pend;
      segmentos <= show ? sh[27:21] : '0;
      anodos <= show ? NUM_DIGITOS'(1) << ei : '0;
      quadro_fim <= frame_end;
    end
endmodule

// File: tb/tb_mux_display_mensagens.sv
// tb_mux_display_mensagens: directed test of the message driver against a slot/frame arithmetic model.
module tb_mux_display_mensagens;
  localparam int N = 4, D = 4, B = 1, P = 2;
  localparam int SL = B + D, FR = N * SL;
  logic clock = 1'b0, reset = 1'b1, habilitar = 1'b0, carregar = 1'b0;
  logic [1:0] sel_mensagem = 2'd0;
  logic [6:0] segmentos;
  logic [N-1:0] anodos;
  logic quadro_fim;
  int total = 0, bad = 0, cyc = 0;
  int m_j = 0, m_fc = 0;
  logic [1:0] m_act = 2'd0, m_pend = 2'd0, nxt;
  logic [6:0] exp_seg = '0;
  logic [N-1:0] exp_an = '0;
  logic exp_qf = 1'b0;
  string msgs [4] = '{"    ", "ErSn", "CAFE", "----"};

  mux_display_mensagens #(.NUM_DIGITOS(N), .DIV_VARREDURA(D), .BLANK_CICLOS(B), .PERIODO_PISCA(P)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .sel_mensagem(sel_mensagem),
    .carregar(carregar), .segmentos(segmentos), .anodos(anodos), .quadro_fim(quadro_fim));

  always #5 clock = ~clock;
  always @(posedge clock or posedge reset) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [6:0] code(input byte ch);
    case (ch)
      "E": return 7'b1001111;
      "r": return 7'b0000101;
      "S": return 7'b1011011;
      "n": return 7'b0010101;
      "C": return 7'b1001110;
      "A": return 7'b1110111;
      "F": return 7'b1000111;
      "-": return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  initial forever begin
    int ph, s, w;
    logic vis;
    @(posedge clock or posedge reset);
    if (reset) begin
      m_j = 0; m_act = 0; m_pend = 0; m_fc = 0;
      exp_seg = '0; exp_an = '0; exp_qf = 1'b0;
    end else begin
      ph = m_j % FR; s = ph / SL; w = ph % SL;
      vis = 1'b1;
`ifdef PISCAR_EN
      vis = !(m_act == 2'd1 && m_fc >= P);
`endif
      exp_an = (habilitar && w >= B && vis) ? N'(1) << s : '0;
      exp_seg = (habilitar && w >= B && vis) ? code(msgs[m_act][s]) : '0;
      exp_qf = habilitar && ph == FR - 1;
      if (exp_qf) begin
        nxt = carregar ? sel_mensagem : m_pend;
        m_fc = (m_act == 2'd1 && nxt == 2'd1) ? (m_fc + 1) % (2 * P) : 0;
        m_act = nxt;
      end
      if (carregar) m_pend = sel_mensagem;
      m_j = habilitar ? m_j + 1 : 0;
    end
    #1;
    chk("model_seg", 32'(segmentos), 32'(exp_seg));
    chk("model_an", 32'(anodos), 32'(exp_an));
    chk("model_qf", 32'(quadro_fim), 32'(exp_qf));
  end

  task automatic wait_edge(input int k);
    while (cyc < k) @(negedge clock);
  endtask

  initial begin
    habilitar = 1'b1; carregar = 1'b1; sel_mensagem = 2'd1;
    repeat (2) @(negedge clock);
    chk("reset_an", 32'(anodos), 0);
    chk("reset_seg", 32'(segmentos), 0);
    reset = 1'b0;
    wait_edge(1); carregar = 1'b0;
    chk("first_dark", 32'(anodos), 0);
    wait_edge(2);  chk("d0_rise", 32'(anodos), 32'b0001); chk("f1_blank", 32'(segmentos), 0);
    wait_edge(7);  chk("d1_an", 32'(anodos), 32'b0010);
    wait_edge(20); chk("qf1", 32'(quadro_fim), 1); chk("d3_an", 32'(anodos), 32'b1000);
    wait_edge(21); chk("qf1_end", 32'(quadro_fim), 0);
    wait_edge(22); chk("f2_E", 32'(segmentos), 32'b1001111);
    wait_edge(27); chk("f2_r", 32'(segmentos), 32'b0000101);
    wait_edge(32); chk("f2_S", 32'(segmentos), 32'b1011011);
    wait_edge(37); chk("f2_n", 32'(segmentos), 32'b0010101);
    wait_edge(40); chk("qf2", 32'(quadro_fim), 1);
    wait_edge(46); carregar = 1'b1; sel_mensagem = 2'd2;
    wait_edge(47); carregar = 1'b0; chk("f3_keep_r", 32'(segmentos), 32'b0000101);
    wait_edge(57); chk("f3_keep_n", 32'(segmentos), 32'b0010101);
    wait_edge(62); chk("f4_C", 32'(segmentos), 32'b1001110);
    wait_edge(67); chk("f4_A", 32'(segmentos), 32'b1110111);
    wait_edge(72); chk("f4_F", 32'(segmentos), 32'b1000111);
    wait_edge(77); chk("f4_E", 32'(segmentos), 32'b1001111);
    wait_edge(80); chk("qf4", 32'(quadro_fim), 1); carregar = 1'b1; sel_mensagem = 2'd3;
    wait_edge(81); carregar = 1'b0;
    wait_edge(82); chk("f5_still_C", 32'(segmentos), 32'b1001110);
    for (int k = 0; k < 4; k++) begin
      wait_edge(102 + 5 * k);
      chk("f6_dash", 32'(segmentos), 32'b0000001);
      chk("f6_an", 32'(anodos), 32'(1 << k));
    end
    wait_edge(122); habilitar = 1'b0;
    wait_edge(123); chk("off_an", 32'(anodos), 0); chk("off_seg", 32'(segmentos), 0);
    carregar = 1'b1; sel_mensagem = 2'd1;
    wait_edge(124); carregar = 1'b0; chk("off_qf", 32'(quadro_fim), 0);
    wait_edge(126); habilitar = 1'b1;
    wait_edge(127); chk("reen_blank", 32'(anodos), 0);
    wait_edge(128); chk("reen_d0", 32'(anodos), 32'b0001); chk("reen_dash", 32'(segmentos), 32'b0000001);
    wait_edge(146); chk("reen_qf", 32'(quadro_fim), 1);
    wait_edge(148); chk("off_commit_E", 32'(segmentos), 32'b1001111);
    wait_edge(150); chk("pre_rst_lit", 32'(anodos), 32'b0001);
    #2 reset = 1'b1;
    #1;
    chk("async_an", 32'(anodos), 0);
    chk("async_seg", 32'(segmentos), 0);
    @(negedge clock); reset = 1'b0;
    wait_edge(2);  chk("post_rst_d0", 32'(anodos), 32'b0001); chk("post_rst_blank", 32'(segmentos), 0);
    wait_edge(22); chk("post_rst_msg0", 32'(segmentos), 0);
    wait_edge(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_display_mensagens.md
Name: mux_display_mensagens

Overview:
- Parametrised, time-multiplexed 7-segment message driver for the coffee-machine front panel.
- Generalises the fixed single-message, externally-counted decoder to:
  - an internal scan counter;
  - N digits;
  - selectable messages;
  - anti-ghost blanking;
  - frame-synchronous message switching.
- Sits between the machine controller (status/error select) and the board's segment/anode pins.

Parameters:
- NUM_DIGITOS, 4: digit positions driven; index 0 = leftmost character, drives anodos[0].
- DIV_VARREDURA, 50000: clock cycles each digit is lit per slot; must be ≥1.
- BLANK_CICLOS, 2: cycles all anodes are off before each digit is lit (anti-ghosting); 0 allowed.
- PERIODO_PISCA, 25: frames per blink half-period; used only with PISCAR_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- habilitar  in  1  display enable; 0 = panel dark.
- sel_mensagem  in  2  0 blank, 1 "ErSn" (sensor error), 2 "CAFE", 3 "----".
- carregar  in  1  one-cycle strobe; captures sel_mensagem as the pending message.
- segmentos  out  7  [6]=a … [0]=g, active-high.
- anodos  out  NUM_DIGITOS  one-hot digit enable, active-high; all-zero = dark.
- quadro_fim  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (asynchronous, immediate):
  - segmentos=0, anodos=0, quadro_fim=0.
  - Scan counter=0, digit index=0, state=BLANK.
  - Active and pending message = 0.
- Character ROM (a..g):
  - E=1001111, r=0000101, S=1011011, n=0010101
  - C=1001110, A=1110111, F=1000111
  - dash=0000001, blank=0000000
- Message mapping: characters map left-to-right onto digits 0..3. Digits ≥4 show blank. If NUM_DIGITOS<4, only the leftmost NUM_DIGITOS characters are shown.
- FSM states: OFF, BLANK, LIT.
  - OFF: entered whenever habilitar=0, from any state. anodos=0, segmentos=0, counters held at 0. Leaving OFF (habilitar=1) goes to BLANK at digit 0.
  - BLANK: lasts BLANK_CICLOS cycles with anodos=0, segmentos=0. If BLANK_CICLOS=0, the state is skipped and LIT follows directly.
  - LIT: lasts DIV_VARREDURA cycles. anodos[idx]=1; segmentos = ROM(active message, idx).
  - Slot end: idx increments and wraps NUM_DIGITOS-1 → 0.
- Slot timing: one slot = BLANK_CICLOS + DIV_VARREDURA cycles; one frame = NUM_DIGITOS slots.
- All outputs are registered.
  - After reset release with habilitar=1, anodos[0] first rises BLANK_CICLOS+1 cycles later.
- quadro_fim: high exactly on the final LIT cycle of digit NUM_DIGITOS-1. Never high in OFF.
- Message update:
  - carregar writes the pending register on the same edge; a later strobe before commit overwrites it (last wins).
  - The active message takes the pending value at the edge ending the quadro_fim cycle, so a new message never tears mid-frame.
  - A strobe coinciding with quadro_fim is committed at the following frame boundary.
  - carregar is accepted in OFF; the pending value commits on the first frame boundary after re-enable.
- Counter width: $clog2 of max(DIV_VARREDURA, BLANK_CICLOS, 1), minimum 1 bit. No overflow is possible.

Optional Feature:
- Macro: PISCAR_EN.
- Defined:
  - While the active message is 1 ("ErSn"), a frame counter toggles visibility every PERIODO_PISCA frames.
  - During invisible frames, anodos=0 and segmentos=0; scan timing and quadro_fim continue unchanged.
  - On commit of any other message, the counter is cleared and the message is visible immediately.
  - After reset, the first PERIODO_PISCA frames are visible.
- Undefined: no frame counter exists; message 1 is shown steadily.

Test Plan (NUM_DIGITOS=4, DIV_VARREDURA=4, BLANK_CICLOS=1, PERIODO_PISCA=2):
- Reset held, then habilitar=1, carregar=1 with sel=1 in cycle 0:
  - frame 1 is blank, anodos visit 0001,0010,0100,1000 for 4 cycles each with 1 dark cycle between;
  - frame 2 shows E,r,S,n = 1001111, 0000101, 1011011, 0010101;
  - quadro_fim pulses every 20 cycles.
- Message switch mid-frame: with message 1 active, carregar sel=2 on digit 1 → the frame finishes "ErSn"; the next frame shows 1001110, 1110111, 1000111, 1001111.
- Boundary strobe: carregar sel=3 in the quadro_fim cycle → the next frame is unchanged; the frame after shows dash (0000001) on all four digits.
- habilitar=0 mid-LIT → next cycle anodos=0; on re-enable, digit 0 lights after 1 blank cycle.
- Asynchronous reset asserted mid-frame, off-edge → outputs are 0 before the next clock edge; the message returns to blank.
- PISCAR_EN defined with message 1 → 2 frames lit, 2 frames dark, repeating; switching to message 2 is steady from its first frame.
